exec_unit: RTL
==============

EXEC_UNIT -- requirements
Module: exec_unit

Interface
REQ-001 The block SHALL have one parameter: OUT_RESET, default 4'h0, the value loaded into outport on reset.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-low (0 = reset).
REQ-004 The block SHALL have port inst, input, 8 bits: current instruction from fetch; [7:4] = opcode, [3:0] = immediate Im.
REQ-005 The block SHALL have port inport, input, 4 bits: external input port, sampled by the IN instructions.
REQ-006 The block SHALL have port isjump, output, 1 bit: combinational jump request to fetch.
REQ-007 The block SHALL have port jumpadrs, output, 4 bits: combinational jump target to fetch.
REQ-008 The block SHALL have port outport, output, 4 bits: registered external output port.
REQ-009 The block SHALL have port rega, output, 4 bits: register A, for observation.
REQ-010 The block SHALL have port regb, output, 4 bits: register B, for observation.
REQ-011 The block SHALL have port carry, output, 1 bit: registered carry flag C.

Function
REQ-012 The block SHALL decode inst combinationally and commit the results at the rising clk edge that ends the cycle: one instruction per cycle, no pipeline, no stall.
REQ-013 The block SHALL implement these opcodes:
- 0000 ADD A,Im: A <= A+Im
- 0101 ADD B,Im: B <= B+Im
- 0011 MOV A,Im: A <= Im
- 0111 MOV B,Im: B <= Im
- 0001 MOV A,B: A <= B
- 0100 MOV B,A: B <= A
- 0010 IN A: A <= inport
- 0110 IN B: B <= inport
- 1001 OUT B: outport <= B
- 1011 OUT Im: outport <= Im
- 1111 JMP Im
- 1110 JNC Im
REQ-014 ADD SHALL be 4-bit modulo-16 arithmetic; C <= carry-out of bit 3 (e.g. A=4'hF, Im=4'h1 gives A=0, C=1).
REQ-015 Every non-ADD instruction, including JMP, JNC and undefined opcodes, SHALL clear C to 0 at its commit edge.
REQ-016 jumpadrs SHALL equal inst[3:0] at all times, independent of opcode.
REQ-017 isjump SHALL be 1 when opcode = 1111, or when opcode = 1110 and the registered C = 0; it SHALL be 0 otherwise.
REQ-018 JNC SHALL test the C value committed by the previous instruction, not the current cycle's result.
REQ-019 Undefined opcodes (1000, 1010, 1100, 1101) SHALL act as NOP: no change to A, B or outport, isjump = 0, C cleared.
REQ-020 Registers not named as the destination of an instruction SHALL hold their values.
REQ-021 inport SHALL be sampled only at the commit edge of IN A / IN B; there is no synchronizer, and inport SHALL be stable around that edge.
REQ-022 When inst is X or Z, the block is not required to behave correctly; after reset it SHALL NOT produce X on any output, provided inst is known.

Reset
REQ-023 While rst = 0, independent of clk, the block SHALL force A = 0, B = 0, C = 0 and outport = OUT_RESET.
REQ-024 Asserting rst mid-instruction SHALL discard that instruction's commit; the first commit after reset SHALL occur at the first rising clk edge with rst = 1.
REQ-025 isjump and jumpadrs SHALL follow inst during reset; fetch is responsible for ignoring them while reset is asserted.

Verification
REQ-026 Reset: rst = 0 with any inst -> rega = 0, regb = 0, carry = 0, outport = 4'h0 without any clk edge.
REQ-027 Sequence 0x33, 0x0E, 0x4_, 0x9_ -> after commit A = 3, then A = 1 with C = 1, then B = 1 with C = 0, then outport = 1.
REQ-028 Carry and JNC:
- 0x3F, 0x01 -> A = 0, C = 1.
- Then 0xE5 -> isjump = 0, jumpadrs = 5, C = 0 after commit.
- Then 0xE7 -> isjump = 1, jumpadrs = 7.
REQ-029 JMP: inst = 0xFA -> isjump = 1, jumpadrs = 4'hA in the same cycle, with no clk edge needed; A, B and outport unchanged after commit.
REQ-030 IN and NOP:
- inport = 4'h9 with 0x20 -> A = 9.
- 0x60 -> B = 9.
- 0x85 -> no change to A, B or outport; C = 0.
REQ-031 Mid-operation reset: assert rst = 0 between two edges while executing 0x0F with A = 2 -> A = 0 and C = 0 immediately; the pending ADD is not committed.

Source files
------------

// File: rtl/exec_unit.sv
// -----------------------------------------------------------------------------
// exec_unit
//
// Execution stage of a tiny 4-bit CPU. Each cycle it decodes the instruction
// presented by fetch, and the rising clk edge that ends the cycle commits the
// result. There is no pipeline and no stall: one instruction per cycle.
//
// Instruction format: inst[7:4] = opcode, inst[3:0] = immediate Im.
//
// Parameters
//   OUT_RESET : value loaded into outport while reset is asserted.
//
// Ports
//   clk      in   1  single clock, rising edge
//   rst      in   1  asynchronous, active-low reset
//   inst     in   8  current instruction from fetch
//   inport   in   4  external input, sampled at the commit edge of IN A / IN B
//   isjump   out  1  combinational jump request to fetch
//   jumpadrs out  4  combinational jump target (always inst[3:0])
//   outport  out  4  registered external output port
//   rega     out  4  register A, for observation
//   regb     out  4  register B, for observation
//   carry    out  1  registered carry flag C
// -----------------------------------------------------------------------------
module exec_unit #(
  parameter logic [3:0] OUT_RESET = 4'h0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] inst,
  input  logic [3:0] inport,
  output logic       isjump,
  output logic [3:0] jumpadrs,
  output logic [3:0] outport,
  output logic [3:0] rega,
  output logic [3:0] regb,
  output logic       carry
);

  typedef enum logic [3:0] {
    OP_ADD_A  = 4'b0000,
    OP_MOV_AB = 4'b0001,
    OP_IN_A   = 4'b0010,
    OP_MOV_A  = 4'b0011,
    OP_MOV_BA = 4'b0100,
    OP_ADD_B  = 4'b0101,
    OP_IN_B   = 4'b0110,
    OP_MOV_B  = 4'b0111,
    OP_OUT_B  = 4'b1001,
    OP_OUT_IM = 4'b1011,
    OP_JNC    = 4'b1110,
    OP_JMP    = 4'b1111
  } opcode_e;

  // Architectural state.
  logic [3:0] reg_a;
  logic [3:0] reg_b;
  logic [3:0] reg_out;
  logic       reg_c;

  // Values to be committed at the end of the current cycle.
  logic [3:0] next_a;
  logic [3:0] next_b;
  logic [3:0] next_out;
  logic       next_c;

  // Instruction fields.
  logic [3:0] opcode;
  logic [3:0] imm;

  assign opcode = inst[7:4];
  assign imm    = inst[3:0];

  // Shared 5-bit adder: bit 4 is the carry-out of bit 3. The operand mux
  // selects B only for ADD B; every other opcode ignores the sum.
  logic [3:0] add_src;
  logic [4:0] add_sum;

  assign add_src = (opcode == OP_ADD_B) ? reg_b : reg_a;
  assign add_sum = {1'b0, add_src} + {1'b0, imm};

  // ---------------------------------------------------------------------------
  // Decode / next-state
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of this block gets a default before the case, so a
    // missing branch can never infer a latch; "hold" is simply the default.
    next_a   = reg_a;
    next_b   = reg_b;
    next_out = reg_out;
    next_c   = 1'b0;  // every non-ADD instruction (including NOPs) clears C

    unique case (opcode)
      OP_ADD_A: begin
        next_a = add_sum[3:0];
        next_c = add_sum[4];
      end
      OP_ADD_B: begin
        next_b = add_sum[3:0];
        next_c = add_sum[4];
      end
      OP_MOV_A:  next_a   = imm;
      OP_MOV_B:  next_b   = imm;
      OP_MOV_AB: next_a   = reg_b;
      OP_MOV_BA: next_b   = reg_a;
      OP_IN_A:   next_a   = inport;
      OP_IN_B:   next_b   = inport;
      OP_OUT_B:  next_out = reg_b;
      OP_OUT_IM: next_out = imm;
      // JMP, JNC and the undefined opcodes change nothing but C.
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Jump request: purely combinational from inst and the committed C, so JNC
  // tests the flag left by the previous instruction, never this cycle's sum.
  // Both outputs follow inst during reset; fetch ignores them then.
  // ---------------------------------------------------------------------------
  always_comb begin
    isjump = 1'b0;
    if (opcode == OP_JMP)
      isjump = 1'b1;
    else if (opcode == OP_JNC)
      isjump = ~reg_c;
  end

  assign jumpadrs = imm;

  // ---------------------------------------------------------------------------
  // Commit. Reset overrides clk immediately, discarding any pending commit.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      reg_a   <= 4'h0;
      reg_b   <= 4'h0;
      reg_out <= OUT_RESET;
      reg_c   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so all four registers update from the
      // same pre-edge values (MOV A,B and MOV B,A read state written here).
      reg_a   <= next_a;
      reg_b   <= next_b;
      reg_out <= next_out;
      reg_c   <= next_c;
    end
  end

  assign rega    = reg_a;
  assign regb    = reg_b;
  assign outport = reg_out;
  assign carry   = reg_c;

endmodule
